// File: rtl/retire_wide_pkg.sv
// retire_wide_pkg: shared commit-stage types, store sizing helper
package retire_wide_pkg;
  localparam int ROB_DEPTH = 16;
  localparam int TAG_W = $clog2(ROB_DEPTH);
  typedef logic [4:0] Register;
  typedef logic [63:0] MemoryWord;
  typedef logic [63:0] Address;
  typedef logic [TAG_W-1:0] tag_t;
  typedef enum logic [1:0] {SB, SH, SW, SD} memory_type;
  typedef enum logic [2:0] {OP_ALU, OP_LOAD, OP_STORE, OP_UCJUMP, OP_CJUMP} op_t;
  typedef struct packed {
    logic regwr;
    logic flush;
  } ctrl_bits_t;
  typedef struct packed {
    logic       ready;
    op_t        op;
    ctrl_bits_t ctrl_bits;
    Register    rd;
    MemoryWord  value;
    Address     pc;
    tag_t       tag;
  } rob_entry;
  typedef struct packed {
    tag_t       tag;
    memory_type mem_type;
    Address     addr;
    MemoryWord  data;
  } lsq_entry;
  typedef struct packed {
    logic    clear;
    Register rd;
    tag_t    tag;
  } map_table_entry;
  function automatic logic [3:0] size_of_store(memory_type t);
    return t == SB ? 4'd1 : t == SH ? 4'd2 : t == SW ? 4'd4 : 4'd8;
  endfunction
endpackage

// File: rtl/retire_wide_store_commit_reg.sv
// store_commit_reg: single-entry store request register with valid/ready drain
module store_commit_reg
  import retire_wide_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  lsq_entry   entry_i,
  input  logic [3:0] size_i,
  input  logic       ready_i,
  output logic       valid_o,
  output lsq_entry   entry_o,
  output logic [3:0] size_o,
  output logic       free_o
);
  logic       valid_q;
  lsq_entry   entry_q;
  logic [3:0] size_q;
  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign entry_o = entry_q;
  assign size_o  = size_q;
  // loads are only issued while free, so the payload never changes under a pending request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      entry_q <= '0;
      size_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
      size_q  <= size_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/retire_wide.sv
// retire_wide: in-order multi-wide commit stage with store port, redirect FSM
// and retired-instruction counter
module retire_wide
  import retire_wide_pkg::*;
#(
  parameter int RETIRE_WIDTH   = 2,
  parameter int RECOVER_CYCLES = 2,
  parameter int CNT_W          = 64,
  localparam int RC_W  = $clog2(ROB_DEPTH + 1),
  localparam int DEC_W = $clog2(RETIRE_WIDTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  rob_entry       [RETIRE_WIDTH-1:0]   rob_head_i,
  input  logic           [RC_W-1:0]           rob_count_i,
  input  lsq_entry                            lsq_head_i,
  input  logic                                retire_stall_i,
  input  logic                                st_ready_i,
  output logic           [RETIRE_WIDTH-1:0]   regwr_o,
  output Register        [RETIRE_WIDTH-1:0]   rd_o,
  output MemoryWord      [RETIRE_WIDTH-1:0]   value_o,
  output map_table_entry [RETIRE_WIDTH-1:0]   mte_o,
  output logic           [RETIRE_WIDTH-1:0]   victim_o,
  output logic           [DEC_W-1:0]          rob_decrement_o,
  output logic                                lsq_decrement_o,
  output logic                                st_valid_o,
  output lsq_entry                            st_entry_o,
  output logic           [3:0]                st_size_o,
  output logic                                flush_o,
  output Address                              jump_to_o,
  output logic           [CNT_W-1:0]          retired_o
);
  typedef enum logic [1:0] {IDLE, FLUSH, RECOVER} state_t;
  state_t           state_q;
  logic [2:0]       cnt_q;
  logic             flush_q;
  Address           jump_to_q;
  logic [CNT_W-1:0] retired_q;
  logic             st_free, st_load, redirect, go, store_seen, hit, ucj;
  Address           target;
  assign flush_o   = flush_q;
  assign jump_to_o = jump_to_q;
  assign retired_o = retired_q;
  // go drops at the first slot that cannot commit and stays low for younger slots
  always_comb begin
    regwr_o         = '0;
    rd_o            = '0;
    value_o         = '0;
    mte_o           = '0;
    victim_o        = '0;
    rob_decrement_o = '0;
    lsq_decrement_o = 1'b0;
    st_load         = 1'b0;
    redirect        = 1'b0;
    target          = '0;
    store_seen      = 1'b0;
    hit             = 1'b0;
    ucj             = 1'b0;
    go              = rst_n && state_q == IDLE && !retire_stall_i;
    for (int i = 0; i < RETIRE_WIDTH; i++) begin
      hit = rob_head_i[i].tag == lsq_head_i.tag;
      ucj = rob_head_i[i].op == OP_UCJUMP;
      if (rob_head_i[i].op == OP_STORE && (store_seen || !hit || !st_free)) go = 1'b0;
      if (go && rob_count_i > RC_W'(i) && rob_head_i[i].ready) begin
        regwr_o[i]      = rob_head_i[i].ctrl_bits.regwr;
        victim_o[i]     = rob_head_i[i].ctrl_bits.regwr;
        rd_o[i]         = rob_head_i[i].rd;
        value_o[i]      = rob_head_i[i].rd == '0 ? '0 :
                          (ucj && rob_head_i[i].ctrl_bits.regwr) ? rob_head_i[i].pc + 64'd4 :
                          rob_head_i[i].value;
        mte_o[i]        = {rob_head_i[i].ctrl_bits.regwr, rob_head_i[i].rd, rob_head_i[i].tag};
        rob_decrement_o = rob_decrement_o + DEC_W'(1);
        lsq_decrement_o = lsq_decrement_o | hit;
        if (rob_head_i[i].op == OP_STORE) begin
          st_load    = 1'b1;
          store_seen = 1'b1;
        end
        if (ucj || (rob_head_i[i].op == OP_CJUMP && rob_head_i[i].ctrl_bits.flush)) begin
          redirect = 1'b1;
          target   = rob_head_i[i].value;
          go       = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end
  store_commit_reg u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (st_load),
    .entry_i (lsq_head_i),
    .size_i  (size_of_store(lsq_head_i.mem_type)),
    .ready_i (st_ready_i),
    .valid_o (st_valid_o),
    .entry_o (st_entry_o),
    .size_o  (st_size_o),
    .free_o  (st_free)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      flush_q   <= 1'b0;
      jump_to_q <= '0;
      retired_q <= '0;
    end else begin
      retired_q <= retired_q + CNT_W'(rob_decrement_o);
      flush_q   <= 1'b0;
      case (state_q)
        IDLE: if (redirect) begin
          state_q   <= FLUSH;
          flush_q   <= 1'b1;
          jump_to_q <= target;
        end
        FLUSH: begin
          state_q <= RECOVER_CYCLES > 0 ? RECOVER : IDLE;
          cnt_q   <= 3'(RECOVER_CYCLES > 0 ? RECOVER_CYCLES - 1 : 0);
        end
        RECOVER: if (cnt_q == '0) state_q <= IDLE; else cnt_q <= cnt_q - 3'd1;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_retire_wide.sv
// tb_retire_wide: directed scenarios plus randomized run against a rule-level commit model
module tb_retire_wide;
  import retire_wide_pkg::*;
  localparam int W   = 2;
  localparam int RC  = 2;
  localparam int CW  = 64;
  localparam int RCW = $clog2(ROB_DEPTH + 1);
  localparam int DW  = $clog2(W + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  rob_entry [W-1:0] rob_head;
  logic [RCW-1:0] rob_count;
  lsq_entry lsq_head;
  logic retire_stall, st_ready;
  logic [W-1:0] regwr, victim;
  Register [W-1:0] rd;
  MemoryWord [W-1:0] value;
  map_table_entry [W-1:0] mte;
  logic [DW-1:0] rob_decrement;
  logic lsq_decrement, st_valid, flush;
  lsq_entry st_entry;
  logic [3:0] st_size;
  Address jump_to;
  logic [CW-1:0] retired;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] e_regwr, e_victim;
  Register [W-1:0] e_rd;
  MemoryWord [W-1:0] e_value;
  map_table_entry [W-1:0] e_mte;
  int e_dec;
  bit e_lsq, e_redirect, e_load;
  Address e_target;
  int m_blocked;
  bit m_pend, m_flush;
  lsq_entry m_entry;
  logic [3:0] m_size;
  Address m_jump;
  logic [CW-1:0] m_retired;

  always #5 clk = ~clk;

  retire_wide #(.RETIRE_WIDTH(W), .RECOVER_CYCLES(RC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .rob_head_i(rob_head), .rob_count_i(rob_count),
    .lsq_head_i(lsq_head), .retire_stall_i(retire_stall), .st_ready_i(st_ready),
    .regwr_o(regwr), .rd_o(rd), .value_o(value), .mte_o(mte), .victim_o(victim),
    .rob_decrement_o(rob_decrement), .lsq_decrement_o(lsq_decrement),
    .st_valid_o(st_valid), .st_entry_o(st_entry), .st_size_o(st_size),
    .flush_o(flush), .jump_to_o(jump_to), .retired_o(retired)
  );

  function automatic rob_entry mk(bit rdy, op_t op, bit rw, bit fl, int r, MemoryWord v, Address pc, int tag);
    mk = '0;
    mk.ready = rdy;
    mk.op = op;
    mk.ctrl_bits.regwr = rw;
    mk.ctrl_bits.flush = fl;
    mk.rd = Register'(r);
    mk.value = v;
    mk.pc = pc;
    mk.tag = tag_t'(tag);
  endfunction

  function automatic lsq_entry mkl(int tag, memory_type m);
    mkl.tag = tag_t'(tag);
    mkl.mem_type = m;
    mkl.addr = 64'h1000 + 64'(tag);
    mkl.data = 64'hdead_0000 + 64'(tag);
  endfunction

  task automatic set_in(input rob_entry a, input rob_entry b, input int cnt, input lsq_entry l, input bit stall, input bit rdy);
    rob_head[0] = a;
    rob_head[1] = b;
    rob_count = RCW'(cnt);
    lsq_head = l;
    retire_stall = stall;
    st_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected commit group, built directly from the commit rules
  task automatic model_comb();
    rob_entry e;
    bit is_st;
    e_regwr = '0; e_victim = '0; e_rd = '0; e_value = '0; e_mte = '0;
    e_dec = 0; e_lsq = 0; e_redirect = 0; e_load = 0; e_target = '0;
    if (!rst_n || m_blocked > 0 || retire_stall) return;
    for (int i = 0; i < W && i < int'(rob_count); i++) begin
      e = rob_head[i];
      is_st = e.op == OP_STORE;
      if (!e.ready) break;
      if (is_st && (e_load || e.tag != lsq_head.tag || (m_pend && !st_ready))) break;
      e_regwr[i] = e.ctrl_bits.regwr;
      e_victim[i] = e.ctrl_bits.regwr;
      e_rd[i] = e.rd;
      if (e.rd == 0) e_value[i] = 0;
      else if (e.op == OP_UCJUMP && e.ctrl_bits.regwr) e_value[i] = e.pc + 4;
      else e_value[i] = e.value;
      e_mte[i].clear = e.ctrl_bits.regwr;
      e_mte[i].rd = e.rd;
      e_mte[i].tag = e.tag;
      e_dec++;
      if (e.tag == lsq_head.tag) e_lsq = 1;
      if (is_st) e_load = 1;
      if (e.op == OP_UCJUMP || (e.op == OP_CJUMP && e.ctrl_bits.flush)) begin
        e_redirect = 1;
        e_target = e.value;
        break;
      end
    end
  endtask

  task automatic model_clock();
    m_retired += CW'(e_dec);
    if (m_pend && st_ready) m_pend = 0;
    if (e_load) begin
      m_pend = 1;
      m_entry = lsq_head;
      m_size = 4'(1 << int'(lsq_head.mem_type));
    end
    if (m_blocked > 0) m_blocked--;
    m_flush = e_redirect;
    if (e_redirect) begin
      m_blocked = 1 + RC;
      m_jump = e_target;
    end
  endtask

  task automatic model_reset();
    m_blocked = 0; m_pend = 0; m_flush = 0; m_entry = '0; m_size = '0; m_jump = '0; m_retired = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(mk(1, OP_ALU, 1, 0, 5, 'h11, 0, 0), mk(1, OP_ALU, 1, 0, 6, 'h22, 0, 1), 2, mkl(15, SD), 0, 1);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({st_valid, st_size, flush, jump_to, retired} !== '0) begin
      errors++; $display("FAIL reset_regs got %h exp 0", {st_valid, st_size, flush, jump_to, retired});
    end
    checks++;
    if ({regwr, rob_decrement, lsq_decrement, victim, value} !== '0) begin
      errors++; $display("FAIL reset_comb got dec %0d regwr %b exp 0", rob_decrement, regwr);
    end
    rob_count = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_pair();
    set_in(mk(1, OP_ALU, 1, 0, 5, 'h11, 'h40, 0), mk(1, OP_ALU, 1, 0, 6, 'h22, 'h44, 1), 2, mkl(15, SD), 0, 0);
    #1;
    checks++;
    if ({regwr, victim, rob_decrement, lsq_decrement} !== {2'b11, 2'b11, 2'd2, 1'b0}) begin
      errors++; $display("FAIL alu_ctrl got regwr %b victim %b dec %0d lsq %b exp 11 11 2 0", regwr, victim, rob_decrement, lsq_decrement);
    end
    checks++;
    if ({value, rd} !== {64'h22, 64'h11, 5'd6, 5'd5}) begin
      errors++; $display("FAIL alu_data got %h %h exp 22 11 rd 6 5", value[1], value[0]);
    end
    tick();
    rob_count = '0;
    #1;
    checks++;
    if (retired !== 64'd2) begin
      errors++; $display("FAIL alu_retired got %0d exp 2", retired);
    end
  endtask

  task automatic test_not_ready();
    set_in(mk(0, OP_ALU, 1, 0, 7, 'h33, 0, 2), mk(1, OP_ALU, 1, 0, 8, 'h44, 0, 3), 2, mkl(15, SD), 0, 0);
    #1;
    checks++;
    if ({rob_decrement, regwr} !== '0) begin
      errors++; $display("FAIL not_ready got dec %0d regwr %b exp 0 00", rob_decrement, regwr);
    end
    tick();
    rob_count = '0;
    #1;
    checks++;
    if (retired !== 64'd2) begin
      errors++; $display("FAIL not_ready_retired got %0d exp 2", retired);
    end
  endtask

  task automatic test_two_stores();
    set_in(mk(1, OP_STORE, 0, 0, 0, 0, 0, 3), mk(1, OP_STORE, 0, 0, 0, 0, 0, 4), 2, mkl(3, SW), 0, 0);
    #1;
    checks++;
    if ({rob_decrement, lsq_decrement} !== {2'd1, 1'b1}) begin
      errors++; $display("FAIL two_st_group got dec %0d lsq %b exp 1 1", rob_decrement, lsq_decrement);
    end
    tick();
    set_in(mk(1, OP_STORE, 0, 0, 0, 0, 0, 4), mk(1, OP_ALU, 1, 0, 9, 'h55, 0, 5), 2, mkl(4, SD), 0, 0);
    #1;
    checks++;
    if ({st_valid, st_size, st_entry} !== {1'b1, 4'd4, mkl(3, SW)}) begin
      errors++; $display("FAIL st_first got v %b size %0d tag %0d exp 1 4 3", st_valid, st_size, st_entry.tag);
    end
    checks++;
    if (rob_decrement !== 2'd0) begin
      errors++; $display("FAIL st_stall got dec %0d exp 0", rob_decrement);
    end
    tick();
    checks++;
    if ({st_valid, st_entry.tag, rob_decrement} !== {1'b1, 4'd3, 2'd0}) begin
      errors++; $display("FAIL st_hold got v %b tag %0d dec %0d exp 1 3 0", st_valid, st_entry.tag, rob_decrement);
    end
    st_ready = 1'b1;
    #1;
    checks++;
    if ({rob_decrement, lsq_decrement} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL st_drain_commit got dec %0d lsq %b exp 2 1", rob_decrement, lsq_decrement);
    end
    tick();
    rob_count = '0;
    st_ready = 1'b0;
    #1;
    checks++;
    if ({st_valid, st_size, st_entry.tag} !== {1'b1, 4'd8, 4'd4}) begin
      errors++; $display("FAIL st_second got v %b size %0d tag %0d exp 1 8 4", st_valid, st_size, st_entry.tag);
    end
    st_ready = 1'b1;
    tick();
    st_ready = 1'b0;
    #1;
    checks++;
    if (st_valid !== 1'b0) begin
      errors++; $display("FAIL st_clear got %b exp 0", st_valid);
    end
  endtask

  task automatic test_ucjump();
    set_in(mk(1, OP_UCJUMP, 1, 0, 1, 'h400, 'h100, 6), mk(1, OP_ALU, 1, 0, 2, 'h66, 0, 7), 2, mkl(15, SD), 0, 0);
    #1;
    checks++;
    if ({rob_decrement, regwr, value[0]} !== {2'd1, 2'b01, 64'h104}) begin
      errors++; $display("FAIL ucj_commit got dec %0d regwr %b val %h exp 1 01 104", rob_decrement, regwr, value[0]);
    end
    tick();
    set_in(mk(1, OP_ALU, 1, 0, 3, 'h77, 0, 8), mk(1, OP_ALU, 1, 0, 4, 'h88, 0, 9), 2, mkl(15, SD), 0, 0);
    #1;
    checks++;
    if ({flush, jump_to, rob_decrement} !== {1'b1, 64'h400, 2'd0}) begin
      errors++; $display("FAIL ucj_flush got f %b to %h dec %0d exp 1 400 0", flush, jump_to, rob_decrement);
    end
    tick();
    checks++;
    if ({flush, rob_decrement} !== {1'b0, 2'd0}) begin
      errors++; $display("FAIL ucj_recover1 got f %b dec %0d exp 0 0", flush, rob_decrement);
    end
    tick();
    checks++;
    if (rob_decrement !== 2'd0) begin
      errors++; $display("FAIL ucj_recover2 got dec %0d exp 0", rob_decrement);
    end
    tick();
    checks++;
    if (rob_decrement !== 2'd2) begin
      errors++; $display("FAIL ucj_resume got dec %0d exp 2", rob_decrement);
    end
    rob_count = '0;
  endtask

  task automatic test_store_through_flush();
    tick();
    set_in(mk(1, OP_STORE, 0, 0, 0, 0, 0, 7), mk(1, OP_CJUMP, 0, 1, 0, 'h800, 'h200, 8), 2, mkl(7, SH), 0, 0);
    #1;
    checks++;
    if ({rob_decrement, lsq_decrement} !== {2'd2, 1'b1}) begin
      errors++; $display("FAIL stf_commit got dec %0d lsq %b exp 2 1", rob_decrement, lsq_decrement);
    end
    tick();
    rob_count = '0;
    #1;
    checks++;
    if ({flush, jump_to, st_valid, st_size} !== {1'b1, 64'h800, 1'b1, 4'd2}) begin
      errors++; $display("FAIL stf_flush got f %b to %h v %b size %0d exp 1 800 1 2", flush, jump_to, st_valid, st_size);
    end
    tick();
    checks++;
    if ({flush, st_valid} !== 2'b01) begin
      errors++; $display("FAIL stf_recover got f %b v %b exp 0 1", flush, st_valid);
    end
    tick();
    st_ready = 1'b1;
    #1;
    checks++;
    if (st_valid !== 1'b1) begin
      errors++; $display("FAIL stf_hold got %b exp 1", st_valid);
    end
    tick();
    st_ready = 1'b0;
    #1;
    checks++;
    if (st_valid !== 1'b0) begin
      errors++; $display("FAIL stf_drain got %b exp 0", st_valid);
    end
  endtask

  task automatic test_reset_mid_recover();
    set_in(mk(1, OP_STORE, 0, 0, 0, 0, 0, 9), mk(1, OP_UCJUMP, 0, 0, 0, 'h900, 'h300, 10), 2, mkl(9, SB), 0, 0);
    #1;
    checks++;
    if (rob_decrement !== 2'd2) begin
      errors++; $display("FAIL rmr_commit got dec %0d exp 2", rob_decrement);
    end
    tick();
    set_in(mk(1, OP_ALU, 1, 0, 3, 'h1, 0, 11), mk(1, OP_ALU, 1, 0, 4, 'h2, 0, 12), 2, mkl(15, SD), 0, 0);
    #1;
    checks++;
    if ({flush, st_valid} !== 2'b11) begin
      errors++; $display("FAIL rmr_flush got f %b v %b exp 1 1", flush, st_valid);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({st_valid, st_size, flush, jump_to, retired} !== '0) begin
      errors++; $display("FAIL rmr_regs got v %b f %b to %h ret %0d exp 0", st_valid, flush, jump_to, retired);
    end
    checks++;
    if ({regwr, rob_decrement, victim, lsq_decrement} !== '0) begin
      errors++; $display("FAIL rmr_comb got dec %0d regwr %b exp 0", rob_decrement, regwr);
    end
    tick();
    rob_count = '0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (retired !== '0) begin
      errors++; $display("FAIL rmr_retired got %0d exp 0", retired);
    end
    rob_count = RCW'(2);
    #1;
    checks++;
    if (rob_decrement !== 2'd2) begin
      errors++; $display("FAIL rmr_idle got dec %0d exp 2", rob_decrement);
    end
    rob_count = '0;
  endtask

  task automatic test_random();
    tag_t base;
    int k;
    tick();
    set_in('0, '0, 0, '0, 0, 0);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 600; n++) begin
      tick();
      checks++;
      if ({st_valid, st_entry, st_size} !== {m_pend, m_entry, m_size}) begin
        errors++; $display("FAIL rnd_store cyc %0d got v %b tag %0d size %0d exp v %b tag %0d size %0d", n, st_valid, st_entry.tag, st_size, m_pend, m_entry.tag, m_size);
      end
      checks++;
      if ({flush, jump_to, retired} !== {m_flush, m_jump, m_retired}) begin
        errors++; $display("FAIL rnd_ctrl cyc %0d got f %b to %h ret %0d exp f %b to %h ret %0d", n, flush, jump_to, retired, m_flush, m_jump, m_retired);
      end
      base = tag_t'($urandom);
      for (int i = 0; i < W; i++) begin
        k = $urandom_range(0, 9);
        rob_head[i] = mk($urandom_range(0, 7) != 0,
                         k < 4 ? OP_ALU : k < 6 ? OP_LOAD : k < 8 ? OP_STORE : k < 9 ? OP_CJUMP : OP_UCJUMP,
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                         {$urandom, $urandom}, {$urandom, $urandom}, int'(base) + i);
      end
      rob_count = RCW'($urandom_range(0, 4) == 0 ? $urandom_range(0, ROB_DEPTH) : $urandom_range(0, W));
      lsq_head = mkl(int'(base) + $urandom_range(0, W), memory_type'($urandom_range(0, 3)));
      retire_stall = $urandom_range(0, 7) == 0;
      st_ready = $urandom_range(0, 2) != 0;
      #1;
      model_comb();
      checks++;
      if ({regwr, victim, rob_decrement, lsq_decrement} !== {e_regwr, e_victim, DW'(e_dec), e_lsq}) begin
        errors++; $display("FAIL rnd_group cyc %0d got regwr %b victim %b dec %0d lsq %b exp %b %b %0d %b", n, regwr, victim, rob_decrement, lsq_decrement, e_regwr, e_victim, e_dec, e_lsq);
      end
      checks++;
      if ({value, rd, mte} !== {e_value, e_rd, e_mte}) begin
        errors++; $display("FAIL rnd_data cyc %0d got %h %h exp %h %h", n, value[1], value[0], e_value[1], e_value[0]);
      end
      model_clock();
    end
    rob_count = '0;
  endtask

  initial begin
    set_in('0, '0, 0, '0, 0, 0);
    test_reset();
    test_alu_pair();
    test_not_ready();
    test_two_stores();
    test_ucjump();
    test_store_through_flush();
    test_reset_mid_recover();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
